// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer and its neighbours
// (fetch and hazard units): FSM state encoding and PC constants.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } pc_state_e;

    localparam int unsigned PC_WIDTH = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int unsigned PC_INC   = 2;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer for a redirect that arrives while fetch is stalled.
// Capture overwrites any older pending target; clear drops it.
module pc_redirect_buf #(
    parameter int unsigned WIDTH = pc_seq_pkg::PC_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_capture,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_target
);

    logic             r_valid;
    logic [WIDTH-1:0] r_target;

    // Pending-redirect register: capture has priority over clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (i_capture) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: sequential increment, redirect,
// stall hold (with buffered redirect) and halt.
// Optional macro PC_SEQ_PERF_EN adds saturating stall/redirect counters.
module pc_sequencer #(
    parameter int unsigned            WIDTH    = pc_seq_pkg::PC_WIDTH,
    parameter logic [WIDTH-1:0]       RESET_PC = pc_seq_pkg::RESET_PC,
    parameter int unsigned            INC      = pc_seq_pkg::PC_INC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             halt_dec,
    output logic [WIDTH-1:0] pc_cur,
    output logic [WIDTH-1:0] pc_plus2,
    output logic             fetch_valid,
`ifdef PC_SEQ_PERF_EN
    output logic [15:0]      stall_cycles,
    output logic [15:0]      redir_count,
`endif
    output logic             halted
);

    import pc_seq_pkg::*;

    localparam logic [WIDTH-1:0] W_INC = WIDTH'(INC);

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_redir_tgt;
    logic             w_capture;
    logic             w_clear;
    logic             w_pend_valid;
    logic [WIDTH-1:0] w_pend_target;

    assign w_pc_inc    = r_pc + W_INC;
    assign w_redir_tgt = {redir_target[WIDTH-1:1], 1'b0};

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redir_buf (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_target  (w_redir_tgt),
        .o_valid   (w_pend_valid),
        .o_target  (w_pend_target)
    );

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_next_pc;
        end
    end

    // Next-state and next-PC selection; a redirect seen while already stalled
    // is buffered instead of applied, and a live redirect beats the buffer
    always_comb begin
        w_state_nxt = r_state;
        w_next_pc   = w_pc_inc;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            RUN: begin
                if (fetch_stall) begin
                    w_state_nxt = STALL;
                    w_next_pc   = redir_valid ? w_redir_tgt : r_pc;
                end else if (redir_valid) begin
                    w_next_pc   = w_redir_tgt;
                end else if (halt_dec) begin
                    w_state_nxt = HALT;
                    w_next_pc   = r_pc;
                end
            end
            STALL: begin
                if (fetch_stall) begin
                    w_next_pc = r_pc;
                    w_capture = redir_valid;
                end else begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                    if (redir_valid)
                        w_next_pc = w_redir_tgt;
                    else if (w_pend_valid)
                        w_next_pc = w_pend_target;
                end
            end
            HALT: begin
                if (redir_valid) begin
                    w_state_nxt = RUN;
                    w_next_pc   = w_redir_tgt;
                end else begin
                    w_next_pc   = r_pc;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_next_pc   = r_pc;
            end
        endcase
    end

    assign pc_cur      = r_pc;
    assign pc_plus2    = w_pc_inc;
    assign halted      = (r_state == HALT);
    assign fetch_valid = !rst && (r_state != HALT) && !fetch_stall && !redir_valid;

`ifdef PC_SEQ_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_redir_count;

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_redir_count  <= '0;
        end else begin
            if (fetch_stall && (r_state != HALT) && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (redir_valid && (r_redir_count != '1))
                r_redir_count <= r_redir_count + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign redir_count  = r_redir_count;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_stall;
    logic        redir_valid;
    logic [15:0] redir_target;
    logic        halt_dec;
    logic [15:0] pc_cur;
    logic [15:0] pc_plus2;
    logic        fetch_valid;
    logic        halted;
`ifdef PC_SEQ_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] redir_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH    (16),
        .RESET_PC (16'h0000),
        .INC      (2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_stall  (fetch_stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .halt_dec     (halt_dec),
        .pc_cur       (pc_cur),
        .pc_plus2     (pc_plus2),
        .fetch_valid  (fetch_valid),
`ifdef PC_SEQ_PERF_EN
        .stall_cycles (stall_cycles),
        .redir_count  (redir_count),
`endif
        .halted       (halted)
    );

    // Advance one clock; outputs settle 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [15:0] tgt);
        redir_valid  = 1'b1;
        redir_target = tgt;
        step();
        redir_valid  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_stall = 1'b0; redir_valid = 1'b0;
        redir_target = 16'h0000; halt_dec = 1'b0;
        #12;
        n_checks++;
        if (pc_cur !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h exp 0000", pc_cur); end
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b exp 0", fetch_valid); end
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_fv got %b exp 1", fetch_valid); end
    endtask

    task automatic test_sequential();
        logic [15:0] exp_pc;
        exp_pc = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pc_cur !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc_cur, exp_pc); end
            n_checks++;
            if (pc_plus2 !== exp_pc + 16'h2) begin n_fail++; $display("FAIL seq_plus2[%0d] got %h exp %h", i, pc_plus2, exp_pc + 16'h2); end
            step();
            exp_pc = exp_pc + 16'h2;
        end
    endtask

    task automatic test_redirect();
        redirect_to(16'h0010);
        n_checks++;
        if (pc_cur !== 16'h0010) begin n_fail++; $display("FAIL redir_setup got %h exp 0010", pc_cur); end
        redir_valid = 1'b1; redir_target = 16'h0041;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL redir_fv got %b exp 0", fetch_valid); end
        step();
        redir_valid = 1'b0;
        n_checks++;
        if (pc_cur !== 16'h0040) begin n_fail++; $display("FAIL redir_odd got %h exp 0040", pc_cur); end
    endtask

    task automatic test_stall_pending();
        redirect_to(16'h0020);
        fetch_stall = 1'b1;
        step();
        n_checks++;
        if (pc_cur !== 16'h0020) begin n_fail++; $display("FAIL stall1_pc got %h exp 0020", pc_cur); end
        redir_valid = 1'b1; redir_target = 16'h0100;
        step();
        redir_valid = 1'b0;
        n_checks++;
        if (pc_cur !== 16'h0020) begin n_fail++; $display("FAIL stall2_pc got %h exp 0020", pc_cur); end
        n_checks++;
        if (u_dut.w_pend_valid !== 1'b1) begin n_fail++; $display("FAIL pend_set got %b exp 1", u_dut.w_pend_valid); end
        step();
        n_checks++;
        if (pc_cur !== 16'h0020) begin n_fail++; $display("FAIL stall3_pc got %h exp 0020", pc_cur); end
        fetch_stall = 1'b0;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL release_fv got %b exp 1", fetch_valid); end
        step();
        n_checks++;
        if (pc_cur !== 16'h0100) begin n_fail++; $display("FAIL release_pc got %h exp 0100", pc_cur); end
        n_checks++;
        if (u_dut.w_pend_valid !== 1'b0) begin n_fail++; $display("FAIL pend_clear got %b exp 0", u_dut.w_pend_valid); end
    endtask

    task automatic test_live_beats_pending();
        fetch_stall = 1'b1;
        step();
        redir_valid = 1'b1; redir_target = 16'h0100;
        step();
        fetch_stall = 1'b0; redir_target = 16'h0200;
        step();
        redir_valid = 1'b0;
        n_checks++;
        if (pc_cur !== 16'h0200) begin n_fail++; $display("FAIL live_pc got %h exp 0200", pc_cur); end
        step();
        n_checks++;
        if (pc_cur !== 16'h0202) begin n_fail++; $display("FAIL live_next got %h exp 0202", pc_cur); end
    endtask

    task automatic test_halt();
        redirect_to(16'h0030);
        halt_dec = 1'b1;
        step();
        halt_dec = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fetch_stall = (i == 2);
            #1;
            n_checks++;
            if (pc_cur !== 16'h0030 || halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_hold[%0d] got pc %h halted %b exp 0030 1", i, pc_cur, halted);
            end
            n_checks++;
            if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_fv[%0d] got %b exp 0", i, fetch_valid); end
            step();
        end
        fetch_stall = 1'b0;
        redirect_to(16'h0050);
        n_checks++;
        if (pc_cur !== 16'h0050 || halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_exit got pc %h halted %b exp 0050 0", pc_cur, halted);
        end
        step();
        n_checks++;
        if (pc_cur !== 16'h0052) begin n_fail++; $display("FAIL halt_run got %h exp 0052", pc_cur); end
    endtask

    task automatic test_wrap_and_reset_mid_stall();
        redirect_to(16'hFFFE);
        n_checks++;
        if (pc_plus2 !== 16'h0000) begin n_fail++; $display("FAIL wrap_plus2 got %h exp 0000", pc_plus2); end
        step();
        n_checks++;
        if (pc_cur !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc got %h exp 0000", pc_cur); end
        redirect_to(16'h0080);
        fetch_stall = 1'b1;
        step();
        redir_valid = 1'b1; redir_target = 16'h0300;
        step();
        redir_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (pc_cur !== 16'h0000) begin n_fail++; $display("FAIL rst_stall_pc got %h exp 0000", pc_cur); end
        n_checks++;
        if (u_dut.w_pend_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pend got %b exp 0", u_dut.w_pend_valid); end
        fetch_stall = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rst_release_fv got %b exp 1", fetch_valid); end
        step();
        n_checks++;
        if (pc_cur !== 16'h0002) begin n_fail++; $display("FAIL no_stale_redir got %h exp 0002", pc_cur); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_pending();
        test_live_beats_pending();
        test_halt();
        test_wrap_and_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
